// File: rtl/mill_modif_mod_pkg.sv
// Modified Miller encoder shared definitions.
// Frame states, symbol codes and the bit-to-symbol mapping.
package mill_modif_mod_pkg;

  localparam int ETU_CLKS_DEF   = 8;
  localparam int PAUSE_CLKS_DEF = 2;
  localparam int CNT_W_DEF      = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SOF  = 3'd1,
    ST_DATA = 3'd2,
    ST_PAR  = 3'd3,
    ST_EOF0 = 3'd4,
    ST_EOFY = 3'd5
  } state_e;

  // Codes shared with the Modified Miller demodulator.
  typedef enum logic [1:0] {
    SYM_X = 2'd0,
    SYM_Y = 2'd1,
    SYM_Z = 2'd2
  } sym_e;

  // '1' is always X; '0' is Z after a Z or a '0', else Y.
  function automatic sym_e map_bit(
    input logic b,
    input logic prev_zero
  );
    if (b)
      return SYM_X;
    if (prev_zero)
      return SYM_Z;
    return SYM_Y;
  endfunction

endpackage

// File: rtl/mill_modif_mod_symbol_gen.sv
// ETU counter and symbol-to-pause shaper.
// Ports: sym/sym_load in; cnt, etu_end, mod (registered, 1 clk behind cnt) out.
module miller_symbol_gen
  import mill_modif_mod_pkg::*;
#(
  parameter int ETU_CLKS   = ETU_CLKS_DEF,
  parameter int PAUSE_CLKS = PAUSE_CLKS_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sym_load,
  input  sym_e             sym,
  output logic [CNT_W-1:0] cnt,
  output logic             etu_end,
  output logic             mod
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(ETU_CLKS - 1);
  localparam logic [CNT_W-1:0] X_LO =
    CNT_W'(ETU_CLKS / 2);
  localparam logic [CNT_W-1:0] X_HI =
    CNT_W'(ETU_CLKS / 2 + PAUSE_CLKS - 1);
  localparam logic [CNT_W-1:0] Z_HI =
    CNT_W'(PAUSE_CLKS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  sym_e             sym_q, sym_d;
  logic             mod_q, mod_d;

  assign etu_end = (cnt_q == CNT_LAST);
  assign cnt     = cnt_q;
  assign mod     = mod_q;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (sym_load || etu_end)
      cnt_d = '0;
    sym_d = sym_load ? sym : sym_q;
    mod_d = 1'b1;
    unique case (sym_q)
      SYM_X:   mod_d = !((cnt_q >= X_LO) &&
                         (cnt_q <= X_HI));
      SYM_Z:   mod_d = !(cnt_q <= Z_HI);
      default: mod_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sym_q <= SYM_Y;
      mod_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      sym_q <= sym_d;
      mod_q <= mod_d;
    end
  end

endmodule

// File: rtl/mill_modif_mod.sv
// Modified Miller transmit encoder: SOF/EOF framing, odd parity, bit fetch.
// Ports: in_start/in_valid/in_data/in_last in; out_ready/mod/busy/done/err out.
module mill_modif_mod
  import mill_modif_mod_pkg::*;
#(
  parameter int ETU_CLKS   = ETU_CLKS_DEF,
  parameter int PAUSE_CLKS = PAUSE_CLKS_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int PARITY_EN  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_start,
  input  logic in_valid,
  input  logic in_data,
  input  logic in_last,
  output logic out_ready,
  output logic out_mod,
  output logic out_busy,
  output logic out_done,
  output logic out_err
);

  localparam logic [CNT_W-1:0] CNT_PRE =
    CNT_W'(ETU_CLKS - 2);

  state_e     state_q, state_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pz_q, pz_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic       par_q, par_d;
  logic       last_q, last_d;

  logic             sg_load;
  sym_e             sg_sym;
  logic [CNT_W-1:0] sg_cnt;
  logic             sg_end;
  logic             sg_mod;

  logic xfer, under, byte_full;
  logic fetch_ok, enc_en, enc_bit;

  miller_symbol_gen #(
    .ETU_CLKS  (ETU_CLKS),
    .PAUSE_CLKS(PAUSE_CLKS),
    .CNT_W     (CNT_W)
  ) u_sg (
    .clk     (clk),
    .rst     (rst),
    .sym_load(sg_load),
    .sym     (sg_sym),
    .cnt     (sg_cnt),
    .etu_end (sg_end),
    .mod     (sg_mod)
  );

  assign byte_full = (PARITY_EN != 0) &&
                     (bitcnt_q == 3'd7);
  assign xfer  = ready_q & in_valid;
  assign under = ready_q & ~in_valid;

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pz_d     = pz_q;
    bitcnt_d = bitcnt_q;
    par_d    = par_q;
    last_d   = last_q;
    sg_load  = 1'b0;
    sg_sym   = SYM_Y;
    enc_en   = 1'b0;
    enc_bit  = 1'b0;
    fetch_ok = 1'b0;

    // Fetch only when the next symbol is a data bit.
    unique case (state_q)
      ST_SOF:  fetch_ok = 1'b1;
      ST_DATA: fetch_ok = !last_q && !byte_full;
      ST_PAR:  fetch_ok = !last_q;
      default: fetch_ok = 1'b0;
    endcase
    // Registered so it is high exactly at the last cnt.
    ready_d = fetch_ok && (sg_cnt == CNT_PRE);

    if (state_q == ST_IDLE) begin
      // Idle holds the counter at 0 with a Y symbol.
      sg_load = 1'b1;
      if (in_start) begin
        state_d  = ST_SOF;
        busy_d   = 1'b1;
        sg_sym   = SYM_Z;
        pz_d     = 1'b1;
        bitcnt_d = 3'd0;
        par_d    = 1'b0;
        last_d   = 1'b0;
      end
    end else if (sg_end) begin
      sg_load = 1'b1;
      unique case (state_q)
        ST_EOF0: state_d = ST_EOFY;
        ST_EOFY: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
        default: begin
          enc_en = 1'b1;
          if (xfer) begin
            state_d = ST_DATA;
            enc_bit = in_data;
            last_d  = in_last;
            if (state_q == ST_DATA) begin
              bitcnt_d = bitcnt_q + 3'd1;
              par_d    = par_q ^ in_data;
            end else begin
              bitcnt_d = 3'd0;
              par_d    = in_data;
            end
          end else if (!under &&
                       state_q == ST_DATA &&
                       byte_full) begin
            state_d = ST_PAR;
            enc_bit = ~par_q;
          end else begin
            // Last bit sent or underrun: close with EOF.
            state_d = ST_EOF0;
            enc_bit = 1'b0;
          end
        end
      endcase
      if (enc_en) begin
        sg_sym = map_bit(enc_bit, pz_q);
        pz_d   = ~enc_bit;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pz_q     <= 1'b0;
      bitcnt_q <= 3'd0;
      par_q    <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pz_q     <= pz_d;
      bitcnt_q <= bitcnt_d;
      par_q    <= par_d;
      last_q   <= last_d;
    end
  end

  assign out_ready = ready_q;
  assign out_mod   = sg_mod;
  assign out_busy  = busy_q;
  assign out_done  = done_q;
  assign out_err   = under;

endmodule

// File: tb/tb_mill_modif_mod.sv
// Bench for mill_modif_mod: per-cycle waveform compare
// against a symbol-level reference built from the frame bits.
module tb_mill_modif_mod;

  localparam int SX = 0;
  localparam int SY = 1;
  localparam int SZ = 2;

  logic clk = 1'b0;
  logic rst;
  logic in_start, in_valid, in_data, in_last;
  logic out_ready, out_mod, out_busy;
  logic out_done, out_err;

  int n_total = 0;
  int n_pass  = 0;

  bit bits[64];
  int syms[$];
  bit fetchq[$];
  int errk;

  always #5 clk = ~clk;

  mill_modif_mod dut (
    .clk      (clk),
    .rst      (rst),
    .in_start (in_start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_ready(out_ready),
    .out_mod  (out_mod),
    .out_busy (out_busy),
    .out_done (out_done),
    .out_err  (out_err)
  );

  task automatic chk(input string tag, input logic got,
                     input logic exp, input int t);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s t=%0d got=%b exp=%b",
                tag, t, got, exp);
  endtask

  // Carrier level for symbol s at counter c (ETU 8, pause 2).
  function automatic logic lvl(input int s, input int c);
    if (s == SX) return !(c >= 4 && c <= 5);
    if (s == SZ) return !(c <= 1);
    return 1'b1;
  endfunction

  // Logical bit stream -> symbols; u>=0 is the underrun bit.
  task automatic build_model(input int n, input int u);
    bit lv[$];
    bit ld[$];
    bit par;
    bit pz;
    int sent;
    sent = (u >= 0) ? u : n;
    par = 1'b0;
    for (int i = 0; i < sent; i++) begin
      lv.push_back(bits[i]);
      ld.push_back(1'b1);
      par ^= bits[i];
      if (i % 8 == 7) begin
        lv.push_back(~par);
        ld.push_back(1'b0);
        par = 1'b0;
      end
    end
    lv.push_back(1'b0);
    ld.push_back(1'b0);
    syms.delete();
    fetchq.delete();
    syms.push_back(SZ);
    pz = 1'b1;
    foreach (lv[j]) begin
      syms.push_back(lv[j] ? SX : (pz ? SZ : SY));
      pz = ~lv[j];
    end
    syms.push_back(SY);
    for (int k = 0; k < syms.size(); k++)
      fetchq.push_back(k < lv.size() ? ld[k] : 1'b0);
    errk = -1;
    if (u >= 0) begin
      errk = lv.size() - 1;
      fetchq[errk] = 1'b1;
    end
  endtask

  task automatic start_frame();
    @(negedge clk);
    in_start = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("idle_busy", out_busy, 1'b0, -1);
    chk("idle_mod", out_mod, 1'b1, -1);
  endtask

  task automatic idle_cycles(input int m);
    for (int i = 0; i < m; i++) begin
      @(negedge clk);
      in_start = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("idle_busy", out_busy, 1'b0, i);
      chk("idle_mod", out_mod, 1'b1, i);
      chk("idle_rdy", out_ready, 1'b0, i);
      chk("idle_done", out_done, 1'b0, i);
    end
  endtask

  task automatic run_frame(input int n, input int u,
                           input int abort_t,
                           input bit chain);
    int idx;
    int nn;
    int k;
    int c;
    logic e_mod, e_rdy, e_err;
    build_model(n, u);
    nn = syms.size() * 8;
    idx = 0;
    for (int t = 0; t <= nn; t++) begin
      @(negedge clk);
      in_valid = (idx < n) && (idx != u);
      in_data  = (idx < n) ? bits[idx] : 1'b0;
      in_last  = (idx == n - 1);
      if (t == nn) in_start = chain;
      else in_start = ($urandom_range(0, 5) == 0);
      #1;
      k = t / 8;
      c = t % 8;
      e_mod = (t == 0) ? 1'b1 :
              lvl(syms[(t-1)/8], (t-1) % 8);
      e_rdy = (t < nn) && (c == 7) && fetchq[k];
      e_err = e_rdy && (k == errk);
      chk("mod", out_mod, e_mod, t);
      chk("ready", out_ready, e_rdy, t);
      chk("err", out_err, e_err, t);
      chk("busy", out_busy, t < nn, t);
      chk("done", out_done, t == nn, t);
      if (e_rdy && in_valid) idx++;
      if (t == abort_t) return;
    end
  endtask

  task automatic load_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) bits[i] = v[i];
  endtask

  task automatic rand_bits();
    for (int i = 0; i < 64; i++)
      bits[i] = 1'($urandom_range(0, 1));
  endtask

  initial begin
    int n;
    int u;
    rst = 1'b1;
    in_start = 1'b0;
    in_valid = 1'b0;
    in_data = 1'b0;
    in_last = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mod", out_mod, 1'b1, -1);
    chk("rst_busy", out_busy, 1'b0, -1);
    chk("rst_rdy", out_ready, 1'b0, -1);
    chk("rst_done", out_done, 1'b0, -1);
    chk("rst_err", out_err, 1'b0, -1);
    rst = 1'b0;
    idle_cycles(2);

    // REQA, 7-bit short frame
    load_byte(8'h26);
    start_frame();
    run_frame(7, -1, -1, 1'b0);
    idle_cycles(2);

    // 0x00 and 0xFF full bytes with parity
    load_byte(8'h00);
    start_frame();
    run_frame(8, -1, -1, 1'b0);
    load_byte(8'hFF);
    start_frame();
    run_frame(8, -1, -1, 1'b0);
    idle_cycles(1);

    // underruns: bit 3, right after SOF, at byte edge
    rand_bits();
    start_frame();
    run_frame(16, 3, -1, 1'b0);
    rand_bits();
    start_frame();
    run_frame(5, 0, -1, 1'b0);
    rand_bits();
    start_frame();
    run_frame(16, 8, -1, 1'b0);
    idle_cycles(2);

    // reset in the middle of an X symbol
    rand_bits();
    bits[0] = 1'b1;
    start_frame();
    run_frame(12, -1, 13, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_mod", out_mod, 1'b1, 13);
    chk("mid_rst_busy", out_busy, 1'b0, 13);
    chk("mid_rst_rdy", out_ready, 1'b0, 13);
    @(negedge clk);
    rst = 1'b0;
    in_start = 1'b0;
    idle_cycles(2);
    rand_bits();
    start_frame();
    run_frame(9, -1, -1, 1'b0);
    idle_cycles(1);

    // back-to-back random frames
    rand_bits();
    start_frame();
    for (int f = 0; f < 8; f++) begin
      rand_bits();
      n = $urandom_range(1, 20);
      u = -1;
      if ($urandom_range(0, 3) == 0)
        u = $urandom_range(0, n - 1);
      run_frame(n, u, -1, f != 7);
    end
    idle_cycles(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
